// File: rtl/dmem_store_monitor_if.sv
// Data-memory store port of the single-cycle core, as seen by the pass/fail monitor.
interface dmem_store_monitor_if;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;

  modport master (output MemWrite, output DataAdr, output WriteData);
  modport slave  (input  MemWrite, input  DataAdr, input  WriteData);
endinterface

// File: rtl/dmem_store_monitor.sv
// Pass/fail monitor on the core's data-memory store port: signature-store detection plus RUN timeout.
// Define STORE_TRACE_EN to add a circular trace of the most recent counted stores.
module dmem_store_monitor #(
  parameter logic [31:0] PASS_ADDR      = 32'd216,
  parameter logic [31:0] PASS_DATA      = 32'd4140,
  parameter int unsigned TIMEOUT_CYCLES = 10000,
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned TRACE_DEPTH    = 8,
  localparam int unsigned IDX_W = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  dmem_store_monitor_if.slave  bus,
  input  logic                 clear,
  input  logic [IDX_W-1:0]     trace_idx,
  output logic                 running,
  output logic                 pass,
  output logic                 fail,
  output logic                 done,
  output logic [CNT_W-1:0]     cycle_count,
  output logic [CNT_W-1:0]     store_count,
  output logic                 trace_valid,
  output logic [31:0]          trace_addr,
  output logic [31:0]          trace_data
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX      = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  logic             running_q, running_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
  logic [CNT_W-1:0] store_count_q, store_count_d;

  logic store_hit;
  logic sig_match;
  logic timeout_hit;
  logic trace_we;
  logic trace_clr;

  always_comb begin
    state_d       = state_q;
    cycle_count_d = cycle_count_q;
    store_count_d = store_count_q;
    pass_d        = pass_q;
    fail_d        = fail_q;
    trace_we      = 1'b0;
    trace_clr     = 1'b0;
    // An unknown strobe falls to the else path, so it never counts or matches.
    store_hit = 1'b0;
    if (bus.MemWrite) store_hit = 1'b1;
    sig_match   = store_hit && (bus.DataAdr == PASS_ADDR) && (bus.WriteData == PASS_DATA);
    timeout_hit = (cycle_count_q == TIMEOUT_LAST);

    if (clear) begin
      state_d       = S_IDLE;
      cycle_count_d = '0;
      store_count_d = '0;
      pass_d        = 1'b0;
      fail_d        = 1'b0;
      trace_clr     = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_RUN;
        S_RUN: begin
          if (cycle_count_q != CNT_MAX) cycle_count_d = cycle_count_q + CNT_W'(1);
          if (store_hit) begin
            trace_we = 1'b1;
            if (store_count_q != CNT_MAX) store_count_d = store_count_q + CNT_W'(1);
          end
          // A signature store on the timeout edge still counts as a pass.
          if (sig_match) begin
            state_d = S_PASS;
            pass_d  = 1'b1;
          end else if (timeout_hit) begin
            state_d = S_FAIL;
            fail_d  = 1'b1;
          end
        end
        default: ;
      endcase
    end

    running_d = (state_d == S_RUN);
    done_d    = pass_d | fail_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      running_q     <= 1'b0;
      pass_q        <= 1'b0;
      fail_q        <= 1'b0;
      done_q        <= 1'b0;
      cycle_count_q <= '0;
      store_count_q <= '0;
    end else begin
      state_q       <= state_d;
      running_q     <= running_d;
      pass_q        <= pass_d;
      fail_q        <= fail_d;
      done_q        <= done_d;
      cycle_count_q <= cycle_count_d;
      store_count_q <= store_count_d;
    end
  end

  assign running     = running_q;
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign done        = done_q;
  assign cycle_count = cycle_count_q;
  assign store_count = store_count_q;

`ifdef STORE_TRACE_EN
  logic [IDX_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [IDX_W-1:0]       rd_ptr;
  logic [TRACE_DEPTH-1:0] ent_valid_q, ent_valid_d;
  logic [31:0]            ent_addr_q [TRACE_DEPTH];
  logic [31:0]            ent_addr_d [TRACE_DEPTH];
  logic [31:0]            ent_data_q [TRACE_DEPTH];
  logic [31:0]            ent_data_d [TRACE_DEPTH];

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    ent_valid_d = ent_valid_q;
    for (int i = 0; i < int'(TRACE_DEPTH); i++) begin
      ent_addr_d[i] = ent_addr_q[i];
      ent_data_d[i] = ent_data_q[i];
    end
    if (trace_clr) begin
      wr_ptr_d    = '0;
      ent_valid_d = '0;
    end else if (trace_we) begin
      ent_addr_d[wr_ptr_q]  = bus.DataAdr;
      ent_data_d[wr_ptr_q]  = bus.WriteData;
      ent_valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d              = wr_ptr_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      ent_valid_q <= '0;
      for (int i = 0; i < int'(TRACE_DEPTH); i++) begin
        ent_addr_q[i] <= '0;
        ent_data_q[i] <= '0;
      end
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      ent_valid_q <= ent_valid_d;
      for (int i = 0; i < int'(TRACE_DEPTH); i++) begin
        ent_addr_q[i] <= ent_addr_d[i];
        ent_data_q[i] <= ent_data_d[i];
      end
    end
  end

  // Index 0 is the newest entry, i.e. the slot just behind the write pointer.
  assign rd_ptr      = wr_ptr_q - IDX_W'(1) - trace_idx;
  assign trace_valid = ent_valid_q[rd_ptr];
  assign trace_addr  = ent_addr_q[rd_ptr];
  assign trace_data  = ent_data_q[rd_ptr];
`else
  logic unused_trace;
  assign unused_trace = ^{trace_idx, trace_we, trace_clr};
  assign trace_valid  = 1'b0;
  assign trace_addr   = '0;
  assign trace_data   = '0;
`endif

endmodule
